// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift unit.
//   WIDTH / SHAMT_W : datapath and shift-amount widths
//   OP_*            : in_op encodings
//   state_t         : sequencer states
//   req_t           : request captured at accept time
package shift_pkg;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;
  } req_t;
endpackage

// File: rtl/shift_core.sv
// Combinational zero-filling logical-right shifter built from SHAMT_W
// 2:1 mux ranks (shift by 1, 2, 4, 8, 16).
//   a      : operand
//   amt    : shift amount
//   result : a >> amt
module shift_core
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] amt,
  output logic [WIDTH-1:0]   result
);
  logic [SHAMT_W:0][WIDTH-1:0] stg;

  assign stg[0] = a;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_rank
    assign stg[k+1] = amt[k] ? (stg[k] >> (2**k)) : stg[k];
  end

  assign result = stg[SHAMT_W];
endmodule

// File: rtl/shift_seq_unit.sv
// Sequential shift/rotate unit. A single right shifter is reused across
// one or two passes; left shifts and rotates are built by bit-reversing
// the operand/result around it, and SRA fills the sign bits with a second
// pass on an all-ones word.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : request handshake; in_a, in_shamt, in_op payload
//   out_valid/out_ready  : result handshake; out_result, out_zero payload
//   ROR_EN               : 1 = op 11 rotates right, 0 = op 11 behaves as SRL
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter bit ROR_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero
);
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  state_t             state, state_nx;
  req_t               req;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   core_in, core_out;
  logic [SHAMT_W-1:0] core_amt, neg_shamt;
  logic               take, is_sll, is_sra, is_ror;

  assign is_sll = (req.op == OP_SLL);
  assign is_sra = (req.op == OP_SRA);
  assign is_ror = ROR_EN && (req.op == OP_ROR);

  // (32 - shamt) mod 32; shamt=0 gives 0 so the second pass re-adds a itself
  assign neg_shamt = ~req.shamt + SHAMT_W'(1);

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign take     = in_valid && in_ready;

  always_comb begin
    core_in  = is_sll ? bit_rev(req.a) : req.a;
    core_amt = req.shamt;
    if (state == PASS2) begin
      core_in = is_sra ? {WIDTH{1'b1}} : bit_rev(req.a);
      if (is_ror) core_amt = neg_shamt;
    end
  end

  shift_core u_core (
    .a      (core_in),
    .amt    (core_amt),
    .result (core_out)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = PASS1;
      PASS1:   state_nx = (is_sra || is_ror) ? PASS2 : DONE;
      PASS2:   state_nx = DONE;
      DONE:    if (out_ready) state_nx = take ? PASS1 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      if (take) req <= '{a: in_a, shamt: in_shamt, op: in_op};
      case (state)
        PASS1: acc <= is_sll ? bit_rev(core_out) : core_out;
        PASS2: begin
          // ~core_out is the mask of the top shamt bits to sign-fill
          if (is_sra) begin
            if (req.a[WIDTH-1]) acc <= acc | ~core_out;
          end else begin
            acc <= acc | bit_rev(core_out);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = (state == DONE);
  assign out_result = acc;
  // gated so reset/idle shows 0 rather than flagging the cleared accumulator
  assign out_zero   = (state == DONE) && (acc == '0);
endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit: hand-computed vectors for every op,
// latency, backpressure, back-to-back accept, out_zero and mid-op reset.
// A second instance checks the ROR_EN=0 fallback to SRL.
module tb_shift_seq_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid, out_ready = 1'b1, out_zero;
  logic [31:0] out_result;

  logic        b_in_valid = 1'b0, b_in_ready;
  logic [31:0] b_in_a = '0;
  logic [4:0]  b_in_shamt = '0;
  logic [1:0]  b_in_op = '0;
  logic        b_out_valid, b_out_zero;
  logic [31:0] b_out_result;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  shift_seq_unit #(.ROR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero)
  );

  shift_seq_unit #(.ROR_EN(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_shamt(b_in_shamt), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .out_result(b_out_result), .out_zero(b_out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  // Issue one request on dut with out_ready=1; lat counts rising edges from
  // the accept edge (inclusive) to the first one that shows out_valid.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [4:0] s, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_shamt = s; in_op = op; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " result"}, out_result, exp);
    chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] held;
    int lat;

    // reset state
    #12;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_zero", {31'b0, out_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);

    run_op("srl 3f>>1",      2'b00, 32'h0000003F, 5'd1,  32'h0000001F, 2);
    run_op("sll 3f<<4",      2'b01, 32'h0000003F, 5'd4,  32'h000003F0, 2);
    run_op("sll 80000001<<31", 2'b01, 32'h80000001, 5'd31, 32'h80000000, 2);
    run_op("sra 80000000>>>4", 2'b10, 32'h80000000, 5'd4,  32'hF8000000, 3);
    run_op("sra 7fffffff>>>16", 2'b10, 32'h7FFFFFFF, 5'd16, 32'h00007FFF, 3);
    run_op("ror 3f,4",       2'b11, 32'h0000003F, 5'd4,  32'hF0000003, 3);
    run_op("ror 3f,0",       2'b11, 32'h0000003F, 5'd0,  32'h0000003F, 3);
    run_op("sra 80000001,0", 2'b10, 32'h80000001, 5'd0,  32'h80000001, 3);
    run_op("sll a5a5,0",     2'b01, 32'h0000A5A5, 5'd0,  32'h0000A5A5, 2);
    run_op("ror 80000001,1", 2'b11, 32'h80000001, 5'd1,  32'hC0000000, 3);

    // ROR_EN=0: op 11 degrades to SRL with 2-cycle latency
    @(negedge clk);
    b_in_valid = 1'b1; b_in_a = 32'h0000003F; b_in_shamt = 5'd4; b_in_op = 2'b11;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("noror result", b_out_result, 32'h00000003);
    chk("noror lat", 32'(lat), 32'd2);

    // backpressure with a zero result
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h1; in_shamt = 5'd1; in_op = 2'b00; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("zero result", out_result, 32'd0);
    chk("zero flag", {31'b0, out_zero}, 32'd1);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall valid", {31'b0, out_valid}, 32'd1);
      chk("stall result", out_result, held);
      chk("stall in_ready", {31'b0, in_ready}, 32'd0);
    end

    // release and accept a new request on the same edge
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_a = 32'h0000003F; in_shamt = 5'd4; in_op = 2'b01;
    #1;
    chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b pass1 valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("b2b valid", {31'b0, out_valid}, 32'd1);
    chk("b2b result", out_result, 32'h000003F0);
    chk("b2b zero", {31'b0, out_zero}, 32'd0);
    @(posedge clk); #1;
    chk("b2b idle", {31'b0, out_valid}, 32'd0);

    // reset during PASS2 of a ROR
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h000000F0; in_shamt = 5'd4; in_op = 2'b11;
    @(posedge clk); #1;            // PASS1
    in_valid = 1'b0;
    @(posedge clk); #1;            // PASS2, accumulator holds 0x0F
    chk("pre-rst acc", out_result, 32'h0000000F);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst out_result", out_result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("midrst no output", {31'b0, out_valid}, 32'd0);
    run_op("post-rst srl", 2'b00, 32'h00000100, 5'd8, 32'h00000001, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1);
  end
endmodule
